audio_sample_buffer: RTL
========================

# audio_sample_buffer

Single-clock stereo sample buffer upstream of the HDMI output path. Accepts stereo PCM pairs from the sound mixer at irregular strobes and presents them as a stable `audio_sample_word[1:0]` pair, updated once per `audio_tick`. The output feeds the `audio_sample_word` input of the HDMI selection stage. It absorbs producer/consumer rate jitter with a small FIFO, a priming threshold and defined underflow/overflow behaviour.

## Interface
- `AUDIO_BIT_WIDTH`, 16, sample width per channel. Must be 16..24 to match the HDMI stage.
- `FIFO_DEPTH`, 8, stereo pairs held. Must be a power of two, ≥4.
- `clk` in 1: the block's only clock.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `in_valid` in 1: a stereo pair is offered this cycle.
- `in_ready` out 1: FIFO not full.
- `in_left` in AUDIO_BIT_WIDTH: left sample, two's complement.
- `in_right` in AUDIO_BIT_WIDTH: right sample, two's complement.
- `audio_tick` in 1: one-cycle strobe at the audio sample rate (e.g. 48 kHz).
- `mute` in 1: force zero output samples.
- `audio_sample_word[1:0]` out AUDIO_BIT_WIDTH each: [0] = left, [1] = right. Registered.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy, 0..FIFO_DEPTH.
- `underflow_count` out 8: saturating count of ticks that found the FIFO empty. Present only with `AUDIO_BUFFER_STATS_EN`.
- `overflow_count` out 8: saturating count of dropped input pairs. Present only with `AUDIO_BUFFER_STATS_EN`.

## Operation
**FIFO behaviour**
- Circular FIFO of {left, right} pairs, with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
- Push: `in_valid && in_ready`.
- Drop: `in_valid && !in_ready`. The pair is discarded and `overflow_count` increments. Producers are not required to stall.

**State machine** (states PRIME and RUN)
- PRIME (reset state)
  - Ticks do not pop. The output holds its current value: zero after reset, last sample after an underflow.
  - Moves to RUN in the cycle after `fifo_level >= FIFO_DEPTH/2`.
- RUN, on `audio_tick`:
  - If `fifo_level > 0`: pop one pair. The output register loads the pair, or zeros if `mute`.
  - If `fifo_level == 0`: underflow. The output holds its last value (zero if `mute`), `underflow_count` increments, and the state returns to PRIME.

**Other rules**
- `mute` affects only the loaded value. Popping, level tracking and the state machine continue unchanged.
- Simultaneous push and pop in the same cycle: `fifo_level` is unchanged.
- Push into an empty FIFO coincident with a tick: there is no bypass. The tick sees level 0 and is treated as an underflow.
- `fifo_level` counts pushes minus pops and never exceeds FIFO_DEPTH.
- Counters saturate at 255 and clear only on reset.
- Reset asserted mid-operation: immediate return to PRIME. FIFO empties, output goes to zero, counters clear.

## Timing
- Reset values:
  - `audio_sample_word[0]` and `[1]` = 0.
  - `fifo_level` = 0.
  - `in_ready` = 1.
  - Counters = 0.
  - State = PRIME.
- Push to level: `fifo_level` updates in the cycle after the push edge.
- `in_ready` is combinational from `fifo_level` (`fifo_level != FIFO_DEPTH`).
- Tick to output: `audio_sample_word` changes on the clock edge that samples `audio_tick`. The new value is visible the following cycle and is stable until the next tick edge.
- PRIME→RUN: the earliest first pop is the first tick sampled after the cycle in which the level reached FIFO_DEPTH/2.
- Output changes at most once per tick, so downstream resynchronisation sees a value held ≥1 tick period.

## Configuration
- `AUDIO_BUFFER_STATS_EN` defined:
  - `underflow_count` and `overflow_count` ports and their logic exist as described.
- `AUDIO_BUFFER_STATS_EN` not defined:
  - Both ports and their counters are omitted.
  - Drop and underflow behaviour is otherwise identical.

## Test plan
- **Reset and priming:** after reset, push 3 pairs (FIFO_DEPTH=8) and issue 5 ticks → output stays 0/0, `fifo_level`=3. Push a 4th pair and tick → output = first pair, `fifo_level`=3.
- **Ordering:** push L/R = 0x0001/0x8001 … 0x0008/0x8008, then 8 ticks → outputs appear in push order, one per tick, each visible the cycle after its tick.
- **Overflow:** push 10 pairs with no ticks → `in_ready`=0 after 8, pairs 9 and 10 dropped, `overflow_count`=2, later ticks yield pairs 1..8 only.
- **Underflow:** in RUN, drain the FIFO and tick once more → output holds the last sample, `underflow_count`=1, state PRIME. Next pop occurs only after 4 new pushes.
- **Mute and coincidence:**
  - `mute`=1 on a tick with level 5 → output 0/0, level 4.
  - Push and tick in the same cycle at level 4 → level stays 4.
- **Async reset mid-stream:** assert reset between clock edges while in RUN with level 6 → output 0/0 and level 0 immediately, counters 0, `in_ready`=1.

Source files
------------

// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer: stereo PCM sample buffer ahead of the HDMI audio path.
// Incoming pairs are pushed into a small circular FIFO whenever the producer
// offers them. Each audio_tick pops one pair into the registered
// audio_sample_word output. A PRIME/RUN state machine refuses to pop until
// the FIFO is half full, which gives the consumer a cushion against jitter.
// Optional feature macro: AUDIO_BUFFER_STATS_EN adds saturating
// underflow/overflow event counters and their output ports.
module audio_sample_buffer #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [AUDIO_BIT_WIDTH-1:0]     in_left,
    input  logic signed [AUDIO_BIT_WIDTH-1:0]     in_right,
    input  logic                                  audio_tick,
    input  logic                                  mute,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0]       audio_sample_word,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level
`ifdef AUDIO_BUFFER_STATS_EN
    ,
    output logic [7:0]                            underflow_count,
    output logic [7:0]                            overflow_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Reject configurations the HDMI stage or the pointer wrap cannot handle.
    if (AUDIO_BIT_WIDTH < 16 || AUDIO_BIT_WIDTH > 24) begin : g_bad_width
        $error("audio_sample_buffer: AUDIO_BIT_WIDTH must be 16..24");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("audio_sample_buffer: FIFO_DEPTH must be a power of two >= 4");
    end

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Increment that sticks at the top of an 8-bit range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Sample that the output register loads on a pop: zero while muted.
    function automatic logic signed [AUDIO_BIT_WIDTH-1:0] mute_sample(
        input logic                              m,
        input logic signed [AUDIO_BIT_WIDTH-1:0] sample
    );
        return m ? '0 : sample;
    endfunction

    logic signed [AUDIO_BIT_WIDTH-1:0] mem_left  [FIFO_DEPTH];
    logic signed [AUDIO_BIT_WIDTH-1:0] mem_right [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    state_t           state;

    logic push;
    logic pop;
    logic level_empty;

    assign in_ready    = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign level_empty = (fifo_level == '0);
    assign push        = in_valid && in_ready;
    // A tick in RUN only pops when data is already stored; there is no
    // bypass path from a same-cycle push.
    assign pop         = (state == RUN) && audio_tick && !level_empty;

    // Sample storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_left[wptr]  <= in_left;
            mem_right[wptr] <= in_right;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at FIFO_DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // PRIME/RUN sequencing together with the registered output pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= PRIME;
            audio_sample_word <= '0;
        end else begin
            case (state)
                PRIME: begin
                    if (fifo_level >= LVL_W'(FIFO_DEPTH / 2)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (audio_tick) begin
                        if (!level_empty) begin
                            audio_sample_word[0] <= mute_sample(mute, mem_left[rptr]);
                            audio_sample_word[1] <= mute_sample(mute, mem_right[rptr]);
                        end else begin
                            // Underflow: hold the last pair and re-prime.
                            state <= PRIME;
                            if (mute) begin
                                audio_sample_word <= '0;
                            end
                        end
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

`ifdef AUDIO_BUFFER_STATS_EN
    logic drop;
    logic underflow;

    assign drop      = in_valid && !in_ready;
    assign underflow = (state == RUN) && audio_tick && level_empty;

    // Saturating event counters for dropped pairs and starved ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_count <= '0;
            overflow_count  <= '0;
        end else begin
            if (underflow) begin
                underflow_count <= sat_inc8(underflow_count);
            end
            if (drop) begin
                overflow_count <= sat_inc8(overflow_count);
            end
        end
    end
`endif

endmodule
